// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life engine and the display stage.
package life_pkg;

    // Default board geometry: one cell per 32x32 sprite on a 640x480 screen.
    localparam int DEF_ROWS  = 15;
    localparam int DEF_COLS  = 20;
    localparam int DEF_GEN_W = 16;

    // Engine state encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } life_state_e;

    // 12-bit RGB colours the display stage uses to paint cells.
    localparam logic [11:0] COLOUR_ALIVE = 12'h0F0;
    localparam logic [11:0] COLOUR_DEAD  = 12'h000;
    localparam logic [11:0] COLOUR_GRID  = 12'h333;

endpackage

// File: rtl/life_if.sv
// Control, pattern-load and read bus between the engine and its users.
interface life_if #(
    parameter int COLS  = 20,
    parameter int GEN_W = 16
);
    logic             i_step;
    logic             i_wr_en;
    logic [3:0]       i_wr_row;
    logic [COLS-1:0]  i_wr_data;
    logic [4:0]       i_rd_x;
    logic [3:0]       i_rd_y;
    logic             o_alive;
    logic             o_busy;
    logic             o_done;
    logic [GEN_W-1:0] o_generation;

    // Controller / display side.
    modport master (
        output i_step, i_wr_en, i_wr_row, i_wr_data, i_rd_x, i_rd_y,
        input  o_alive, o_busy, o_done, o_generation
    );

    // Engine side.
    modport slave (
        input  i_step, i_wr_en, i_wr_row, i_wr_data, i_rd_x, i_rd_y,
        output o_alive, o_busy, o_done, o_generation
    );
endinterface

// File: rtl/life_row_next.sv
// Combinational B3/S23 update of one board row with column wrap-around.
module life_row_next #(
    parameter int COLS = 20
) (
    input  logic [COLS-1:0] above_i,
    input  logic [COLS-1:0] centre_i,
    input  logic [COLS-1:0] below_i,
    output logic [COLS-1:0] next_o
);
    for (genvar c = 0; c < COLS; c++) begin : g_col
        // Left/right neighbours wrap around the board edges.
        localparam int L = (c == 0) ? COLS - 1 : c - 1;
        localparam int R = (c == COLS - 1) ? 0 : c + 1;
        logic [3:0] n;

        assign n = {3'b0, above_i[L]}  + {3'b0, above_i[c]}  + {3'b0, above_i[R]}
                 + {3'b0, centre_i[L]}                       + {3'b0, centre_i[R]}
                 + {3'b0, below_i[L]}  + {3'b0, below_i[c]}  + {3'b0, below_i[R]};

        assign next_o[c] = (n == 4'd3) | (centre_i[c] & (n == 4'd2));
    end
endmodule

// File: rtl/life_engine.sv
// Double-buffered Game-of-Life engine: one row per clock into nxt, then a
// single-cycle commit into cur, which is the only bank the read port sees.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int GEN_W = DEF_GEN_W
) (
    input  logic  i_clk,
    input  logic  i_rst,
    life_if.slave bus
);
    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [3:0] ROWS_L   = 4'(ROWS);
    localparam logic [4:0] COLS_L   = 5'(COLS);

    life_state_e      state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [COLS-1:0]  cur_q [ROWS];
    logic [COLS-1:0]  nxt_q [ROWS];
    logic [GEN_W-1:0] gen_q;
    logic             done_q;
    logic             busy;
    logic             alive;
    logic [3:0]       up_idx, dn_idx;
    logic [COLS-1:0]  row_new;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: step only accepted from IDLE, ROWS compute cycles, one commit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.i_step) state_d = ST_COMPUTE;
            ST_COMPUTE: if (row_q == ROW_LAST) state_d = ST_COMMIT;
            ST_COMMIT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Row counter walks 0..ROWS-1 during COMPUTE and parks at 0 otherwise.
    always_comb begin
        row_d = 4'd0;
        if (state_q == ST_COMPUTE && row_q != ROW_LAST) row_d = row_q + 4'd1;
    end

    // Row counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) row_q <= 4'd0;
        else       row_q <= row_d;
    end

    // Vertical neighbours wrap top-to-bottom.
    always_comb begin
        up_idx = (row_q == 4'd0)     ? ROW_LAST : row_q - 4'd1;
        dn_idx = (row_q == ROW_LAST) ? 4'd0     : row_q + 4'd1;
    end

    life_row_next #(.COLS(COLS)) u_row_next (
        .above_i  (cur_q[up_idx]),
        .centre_i (cur_q[row_q]),
        .below_i  (cur_q[dn_idx]),
        .next_o   (row_new)
    );

    // Board banks: pattern load in IDLE, row fill in COMPUTE, bank copy in COMMIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < ROWS; r++) begin
                cur_q[r] <= '0;
                nxt_q[r] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_wr_en && bus.i_wr_row < ROWS_L) cur_q[bus.i_wr_row] <= bus.i_wr_data;
                end
                ST_COMPUTE: nxt_q[row_q] <= row_new;
                ST_COMMIT: begin
                    for (int r = 0; r < ROWS; r++) cur_q[r] <= nxt_q[r];
                end
                default: ;
            endcase
        end
    end

    // Generation counter and done pulse, both updated at the commit edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gen_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_COMMIT);
            if (state_q == ST_COMMIT) gen_q <= gen_q + 1'b1;
        end
    end

    // Read mux on the visible bank; off-board coordinates read as dead.
    always_comb begin
        alive = 1'b0;
        if (bus.i_rd_y < ROWS_L && bus.i_rd_x < COLS_L) alive = cur_q[bus.i_rd_y][bus.i_rd_x];
    end

    assign bus.o_alive      = alive;
    assign bus.o_busy       = busy;
    assign bus.o_done       = done_q;
    assign bus.o_generation = gen_q;
endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: reference model plus scoreboard queue.
module tb_life_engine;
    localparam int ROWS = 15;
    localparam int COLS = 20;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;
    typedef struct {
        board_t board;
        int     gen;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    life_if #(.COLS(COLS), .GEN_W(16)) bus ();
    life_if #(.COLS(COLS), .GEN_W(2))  bus2 ();

    life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(16)) dut (
        .i_clk (clk), .i_rst (rst), .bus (bus)
    );
    life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(2)) dut2 (
        .i_clk (clk), .i_rst (rst), .bus (bus2)
    );

    int     vecs = 0;
    int     errs = 0;
    board_t mdl;
    int     mdl_gen;
    exp_t   sb[$];
    int     sb2[$];

    function automatic board_t life_step(input board_t b);
        board_t nb;
        int n;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0)
                            n += int'(b[(y + dy + ROWS) % ROWS][(x + dx + COLS) % COLS]);
                nb[y][x] = (n == 3) || (b[y][x] && n == 2);
            end
        return nb;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        mdl = '0;
        mdl_gen = 0;
        sb.delete();
        sb2.delete();
    endtask

    task automatic load_row(input int r, input logic [COLS-1:0] d);
        bus.i_wr_en = 1'b1; bus.i_wr_row = 4'(r); bus.i_wr_data = d;
        cyc();
        bus.i_wr_en = 1'b0;
        if (r < ROWS) mdl[r] = d;
    endtask

    task automatic read_cell(input int x, input int y, output logic v);
        bus.i_rd_x = 5'(x); bus.i_rd_y = 4'(y);
        #1 v = bus.o_alive;
    endtask

    task automatic read_board(output board_t b);
        logic v;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                read_cell(x, y, v);
                b[y][x] = v;
            end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_board(input string name, input board_t exp);
        board_t got;
        read_board(got);
        for (int y = 0; y < ROWS; y++) begin
            vecs++;
            if (got[y] !== exp[y]) begin
                errs++;
                $display("FAIL %s row %0d: got %h required %h", name, y, got[y], exp[y]);
            end
        end
    endtask

    // Issue a step from IDLE and push the model's prediction.
    task automatic issue_step();
        exp_t e;
        bus.i_step = 1'b1;
        mdl = life_step(mdl);
        mdl_gen++;
        e.board = mdl; e.gen = mdl_gen;
        sb.push_back(e);
        cyc();
        bus.i_step = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (bus.o_done !== 1'b1 && lat < 60) begin cyc(); lat++; end
        vecs++;
        if (bus.o_done !== 1'b1) begin
            errs++;
            $display("FAIL done_timeout: o_done=%b after %0d cycles, required 1", bus.o_done, lat);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        vecs++;
        if (sb.size() == 0) begin
            errs++;
            $display("FAIL %s_sb: scoreboard empty, required one entry", name);
            return;
        end
        e = sb.pop_front();
        vecs++;
        if (bus.o_generation !== 16'(e.gen)) begin
            errs++;
            $display("FAIL %s_gen: got %0d required %0d", name, bus.o_generation, e.gen);
        end
        check_board(name, e.board);
    endtask

    task automatic step_and_check(input string name);
        int lat;
        issue_step();
        wait_done(1, lat);
        vecs++;
        if (lat != 17 || bus.o_busy !== 1'b0) begin
            errs++;
            $display("FAIL %s_lat: got %0d cycles busy=%b, required 17 cycles busy=0", name, lat, bus.o_busy);
        end
        cyc();
        vecs++;
        if (bus.o_done !== 1'b0) begin
            errs++;
            $display("FAIL %s_pulse: o_done=%b one cycle later, required 0", name, bus.o_done);
        end
        pop_check(name);
    endtask

    task automatic test_reset();
        apply_reset();
        vecs++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_generation !== 16'd0 || bus2.o_generation !== 2'd0) begin
            errs++;
            $display("FAIL reset_outputs: busy=%b done=%b gen=%0d gen2=%0d, required 0 0 0 0",
                     bus.o_busy, bus.o_done, bus.o_generation, bus2.o_generation);
        end
        check_board("reset_board", '0);
    endtask

    task automatic test_blinker();
        board_t vert, horiz;
        apply_reset();
        load_row(5, 20'h00070);
        horiz = '0; horiz[5] = 20'h00070;
        vert = '0; vert[4][5] = 1'b1; vert[5][5] = 1'b1; vert[6][5] = 1'b1;
        step_and_check("blinker1");
        check_board("blinker1_const", vert);
        step_and_check("blinker2");
        check_board("blinker2_const", horiz);
    endtask

    task automatic test_wrap();
        board_t c;
        apply_reset();
        load_row(7, 20'h80003);
        step_and_check("wrap_col");
        c = '0; c[6][0] = 1'b1; c[7][0] = 1'b1; c[8][0] = 1'b1;
        check_board("wrap_col_const", c);
        apply_reset();
        load_row(14, 20'h00038);
        step_and_check("wrap_row");
        c = '0; c[13][4] = 1'b1; c[14][4] = 1'b1; c[0][4] = 1'b1;
        check_board("wrap_row_const", c);
    endtask

    task automatic test_still_life();
        board_t c;
        logic a, b, o, p;
        apply_reset();
        load_row(2, 20'h00C00);
        load_row(3, 20'h00C00);
        c = mdl;
        step_and_check("block");
        check_board("block_const", c);
        read_cell(10, 2, a);
        read_cell(12, 2, b);
        read_cell(25, 3, o);
        read_cell(5, 15, p);
        vecs++;
        if (a !== 1'b1 || b !== 1'b0 || o !== 1'b0 || p !== 1'b0) begin
            errs++;
            $display("FAIL read_port: (2,10)=%b (2,12)=%b (3,25)=%b (15,5)=%b, required 1 0 0 0", a, b, o, p);
        end
        cyc();
    endtask

    task automatic test_busy_drop();
        int lat, extra;
        logic old_on, new_on;
        apply_reset();
        load_row(5, 20'h00070);
        issue_step();
        cyc(); cyc(); cyc();
        read_cell(4, 5, old_on);
        read_cell(5, 4, new_on);
        vecs++;
        if (bus.o_busy !== 1'b1 || old_on !== 1'b1 || new_on !== 1'b0) begin
            errs++;
            $display("FAIL mid_compute: busy=%b (5,4)=%b (4,5)=%b, required 1 1 0", bus.o_busy, old_on, new_on);
        end
        bus.i_step = 1'b1; bus.i_wr_en = 1'b1; bus.i_wr_row = 4'd0; bus.i_wr_data = '1;
        cyc();
        bus.i_step = 1'b0; bus.i_wr_en = 1'b0;
        wait_done(5, lat);
        vecs++;
        if (lat != 17) begin
            errs++;
            $display("FAIL busy_lat: got %0d cycles, required 17", lat);
        end
        extra = 0;
        for (int i = 0; i < 25; i++) begin cyc(); if (bus.o_done === 1'b1) extra++; end
        vecs++;
        if (extra != 0) begin
            errs++;
            $display("FAIL busy_extra_done: got %0d extra pulses, required 0", extra);
        end
        pop_check("busy_drop");
    endtask

    task automatic test_reset_mid();
        int extra;
        apply_reset();
        load_row(5, 20'h00070);
        issue_step();
        for (int i = 0; i < 7; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mdl = '0; mdl_gen = 0; sb.delete();
        vecs++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_generation !== 16'd0) begin
            errs++;
            $display("FAIL reset_mid: busy=%b done=%b gen=%0d, required 0 0 0", bus.o_busy, bus.o_done, bus.o_generation);
        end
        check_board("reset_mid_board", '0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin cyc(); if (bus.o_done === 1'b1) extra++; end
        vecs++;
        if (extra != 0) begin
            errs++;
            $display("FAIL reset_mid_done: got %0d stray pulses, required 0", extra);
        end
        load_row(5, 20'h00070);
        step_and_check("after_reset");
    endtask

    task automatic test_counter_wrap();
        int lat;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            bus2.i_step = 1'b1;
            sb2.push_back((k + 1) % 4);
            cyc();
            bus2.i_step = 1'b0;
            lat = 1;
            while (bus2.o_done !== 1'b1 && lat < 60) begin cyc(); lat++; end
            vecs++;
            if (bus2.o_done !== 1'b1 || lat != 17) begin
                errs++;
                $display("FAIL wrap_done%0d: done=%b after %0d cycles, required 1 after 17", k, bus2.o_done, lat);
            end
            vecs++;
            if (bus2.o_generation !== 2'(sb2.pop_front())) begin
                errs++;
                $display("FAIL wrap_gen%0d: got %0d required %0d", k, bus2.o_generation, (k + 1) % 4);
            end
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_step = 1'b0;  bus.i_wr_en = 1'b0;  bus.i_wr_row = '0;  bus.i_wr_data = '0;
        bus.i_rd_x = '0;    bus.i_rd_y = '0;
        bus2.i_step = 1'b0; bus2.i_wr_en = 1'b0; bus2.i_wr_row = '0; bus2.i_wr_data = '0;
        bus2.i_rd_x = '0;   bus2.i_rd_y = '0;
        cyc();
        test_reset();
        test_blinker();
        test_wrap();
        test_still_life();
        test_busy_drop();
        test_reset_mid();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
Game-of-Life generation engine that sits directly upstream of the sprite-matrix display stage.
- Holds the 20 x 15 cell board (one cell per 32x32 sprite).
- On each step request, computes the next generation one row per clock under B3/S23 rules with toroidal wrap.
- Exposes a read port that the display stage indexes with sprite_x/sprite_y.
- Double-buffered, so the display never sees a partially updated board.

Parameters:
- ROWS, 15, number of board rows (sprite_y range 0..ROWS-1)
- COLS, 20, number of board columns (sprite_x range 0..COLS-1)
- GEN_W, 16, width of the generation counter

Ports:
- i_clk  in  1  system clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_step  in  1  request one generation update; sampled only in IDLE
- i_wr_en  in  1  write one full board row (pattern load); honoured only in IDLE
- i_wr_row  in  4  row index for write; values >= ROWS are ignored
- i_wr_data  in  COLS  row contents; bit c = column c, 1 = alive
- i_rd_x  in  5  read column (sprite_x)
- i_rd_y  in  4  read row (sprite_y)
- o_alive  out  1  combinational cell state of the current board at (i_rd_y, i_rd_x)
- o_busy  out  1  high while a generation is being computed
- o_done  out  1  one-cycle pulse when a new generation becomes visible
- o_generation  out  GEN_W  count of committed generations

Behaviour:
- Reset (i_rst high at a clock edge):
  - cur and nxt boards cleared to all-dead.
  - State goes to IDLE; row counter = 0.
  - o_busy = 0, o_done = 0, o_generation = 0.
  - Reset wins over every other input, including mid-COMPUTE; a partial nxt is discarded.
- Storage: cur[ROWS] and nxt[ROWS], each COLS bits wide, held in registers.
- Read port:
  - o_alive = cur[i_rd_y][i_rd_x] when i_rd_y < ROWS and i_rd_x < COLS, else 0.
  - Always reflects cur, never nxt, including throughout COMPUTE.
- States are IDLE, COMPUTE and COMMIT.
- IDLE:
  - i_wr_en with a valid row writes cur[i_wr_row] <= i_wr_data.
  - i_step = 1 moves to COMPUTE with row = 0.
  - If i_wr_en and i_step arrive in the same cycle, the write lands at that edge and the step computes from the written board.
- COMPUTE:
  - Each cycle computes nxt[row] from cur[row-1], cur[row], cur[row+1], with row indices mod ROWS and column indices mod COLS (toroidal).
  - row increments each cycle; after row = ROWS-1 the state moves to COMMIT.
  - Exactly ROWS cycles are spent in COMPUTE.
- COMMIT (one cycle):
  - cur <= nxt (all rows).
  - o_generation increments, wrapping modulo 2^GEN_W.
  - o_done is registered high for the following cycle only.
  - State returns to IDLE.
- Cell rule:
  - n = live count of the 8 neighbours, 4-bit, range 0..8.
  - next = (n == 3) | (alive & n == 2).
- o_busy is 1 in COMPUTE and COMMIT, 0 in IDLE.
- Latency: i_step sampled high at edge E.
  - COMPUTE occupies E+1..E+ROWS; COMMIT follows at E+ROWS+1.
  - The new board, o_done = 1, o_busy = 0 and o_generation+1 are all visible in the cycle after the COMMIT edge, i.e. E+ROWS+2 (edge 17 for ROWS = 15).
- i_step and i_wr_en while busy are silently dropped; they are not queued.
- Empty board stays empty; step still runs and o_generation still increments.

Decomposition:
- Shared package life_pkg holds:
  - ROWS/COLS defaults.
  - The state encoding (IDLE = 2'd0, COMPUTE = 2'd1, COMMIT = 2'd2).
  - Colour constants shared with the display stage.
- One natural sub-module: life_row_next. It is purely combinational: it takes the three COLS-bit rows (above, centre, below) and returns the COLS-bit next row, with column wrap handled internally.
- life_engine owns the FSM, counters, both board banks and the read mux.

Test Plan:
- Blinker: load row 5 = bits 4, 5, 6 set; pulse i_step.
  - Exactly 17 cycles after the step edge: o_done = 1 and o_generation = 1.
  - cur has col 5 set in rows 4, 5, 6 and nothing else.
  - A second step returns the board to the original pattern and o_generation = 2.
- Toroidal wrap: load row 7 = bits 19, 0, 1; step → col 0 set in rows 6, 7, 8 only. Also load row 14 = bits 3, 4, 5; step → col 4 set in rows 13, 14, 0 only.
- Still life and read port: load 2x2 block at rows 2–3, cols 10–11; step.
  - Board is unchanged.
  - o_alive = 1 at (y = 2, x = 10) and 0 at (y = 2, x = 12).
  - Read at (x = 25, y = 3) returns 0.
- Busy drops: step, then during COMPUTE pulse i_step and i_wr_en (row 0 = all ones).
  - Only one o_done is seen; row 0 is not written; o_generation advances by 1.
  - o_alive sampled mid-COMPUTE shows the old board.
- Reset mid-operation: step, assert i_rst at cycle 8 of COMPUTE.
  - Next cycle: o_busy = 0, o_done = 0, o_generation = 0, all cells dead.
  - A new load-and-step then completes normally.
- Counter wrap: GEN_W = 2, four steps on an empty board → o_generation sequence 1, 2, 3, 0.
